// File: rtl/thiele_loader_pkg.sv
// ============================================================================
// thiele_loader_pkg : shared state encoding, defaults and edge validity check
// Rev 1.0
// ============================================================================
`default_nettype none

package thiele_loader_pkg;

  localparam int DEFAULT_IDX_W = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } state_e;

  // An edge is usable only if both endpoints exist and it is not a self-loop.
  function automatic logic edge_ok(input int u, input int v, input int nodes);
    return (u < nodes) && (v < nodes) && (u != v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/thiele_adjacency_regs.sv
// ============================================================================
// thiele_adjacency_regs : symmetric NODES x NODES adjacency bit matrix
// Rev 1.0
// ============================================================================
`default_nettype none

module thiele_adjacency_regs
  import thiele_loader_pkg::*;
#(
  parameter int NODES = 9,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     set_en,
  input  logic [IDX_W-1:0]         u,
  input  logic [IDX_W-1:0]         v,
  output logic [NODES*NODES-1:0]   adjacency
);

  logic [NODES*NODES-1:0] adj_d;
  logic [NODES*NODES-1:0] adj_q;

  for (genvar r = 0; r < NODES; r++) begin : g_row
    for (genvar c = 0; c < NODES; c++) begin : g_col
      logic hit;
      // Either orientation of the edge lands on this cell, keeping the matrix symmetric.
      assign hit = set_en &&
                   (((u == IDX_W'(r)) && (v == IDX_W'(c))) ||
                    ((u == IDX_W'(c)) && (v == IDX_W'(r))));
      assign adj_d[r*NODES+c] = !clear && (adj_q[r*NODES+c] || hit);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adj_q <= '0;
    end else begin
      adj_q <= adj_d;
    end
  end

  assign adjacency = adj_q;

endmodule

`default_nettype wire

// File: rtl/thiele_graph_loader.sv
// ============================================================================
// thiele_graph_loader : edge-stream loader, solver launcher and result latch
// Optional watchdog: define THIELE_LOADER_WATCHDOG_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module thiele_graph_loader
  import thiele_loader_pkg::*;
#(
  parameter int NODES           = 9,
  parameter int IDX_W           = DEFAULT_IDX_W,
  parameter int CNT_W           = DEFAULT_CNT_W,
  parameter int WATCHDOG_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   edge_valid,
  output logic                   edge_ready,
  input  logic [IDX_W-1:0]       edge_u,
  input  logic [IDX_W-1:0]       edge_v,
  input  logic                   edge_last,
  output logic [NODES*NODES-1:0] adjacency,
  output logic                   solver_start,
  input  logic                   solver_done,
  input  logic                   solver_success,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   result_success,
  output logic                   load_error,
  output logic [CNT_W-1:0]       edge_count,
  output logic [CNT_W-1:0]       reject_count,
  output logic                   timeout
);

  state_e           state_q, state_d;
  logic             solver_start_q, solver_start_d;
  logic             result_valid_q, result_valid_d;
  logic             result_success_q, result_success_d;
  logic             load_error_q, load_error_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic [CNT_W-1:0] reject_count_q, reject_count_d;
  logic             restart;
  logic             beat_ok;
  logic             adj_clear;
  logic             adj_set;

`ifdef THIELE_LOADER_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`else
  logic [31:0] unused_watchdog;
  assign unused_watchdog = WATCHDOG_CYCLES;
`endif

  assign restart = load_start && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign beat_ok = edge_ok(32'(edge_u), 32'(edge_v), NODES);

  always_comb begin
    state_d          = state_q;
    solver_start_d   = solver_start_q;
    result_valid_d   = result_valid_q;
    result_success_d = result_success_q;
    load_error_d     = load_error_q;
    timeout_d        = timeout_q;
    edge_count_d     = edge_count_q;
    reject_count_d   = reject_count_q;
    adj_clear        = 1'b0;
    adj_set          = 1'b0;
`ifdef THIELE_LOADER_WATCHDOG_EN
    wd_cnt_d         = '0;
`endif
    if (restart) begin
      // A new graph wins over any beat presented in the same cycle.
      state_d          = ST_LOAD;
      adj_clear        = 1'b1;
      edge_count_d     = '0;
      reject_count_d   = '0;
      result_valid_d   = 1'b0;
      result_success_d = 1'b0;
      load_error_d     = 1'b0;
      timeout_d        = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (edge_valid) begin
            if (beat_ok) begin
              adj_set = 1'b1;
              if (edge_count_q != '1) edge_count_d = edge_count_q + CNT_W'(1);
            end else begin
              load_error_d = 1'b1;
              if (reject_count_q != '1) reject_count_d = reject_count_q + CNT_W'(1);
            end
            if (edge_last) begin
              if (load_error_q || !beat_ok) begin
                result_valid_d   = 1'b1;
                result_success_d = 1'b0;
                state_d          = ST_IDLE;
              end else begin
                solver_start_d = 1'b1;
                state_d        = ST_WAIT_DONE;
              end
            end
          end
        end
        ST_WAIT_DONE: begin
`ifdef THIELE_LOADER_WATCHDOG_EN
          wd_cnt_d = wd_cnt_q + WD_W'(1);
`endif
          if (solver_done) begin
            result_success_d = solver_success;
            solver_start_d   = 1'b0;
            state_d          = ST_RELEASE;
          end
`ifdef THIELE_LOADER_WATCHDOG_EN
          else if (wd_cnt_q == WD_LAST) begin
            timeout_d        = 1'b1;
            result_success_d = 1'b0;
            solver_start_d   = 1'b0;
            state_d          = ST_RELEASE;
          end
`endif
        end
        ST_RELEASE: begin
          // The solver leaves its finished state only after start drops.
          if (!solver_done) begin
            result_valid_d = 1'b1;
            state_d        = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      solver_start_q   <= 1'b0;
      result_valid_q   <= 1'b0;
      result_success_q <= 1'b0;
      load_error_q     <= 1'b0;
      timeout_q        <= 1'b0;
      edge_count_q     <= '0;
      reject_count_q   <= '0;
    end else begin
      state_q          <= state_d;
      solver_start_q   <= solver_start_d;
      result_valid_q   <= result_valid_d;
      result_success_q <= result_success_d;
      load_error_q     <= load_error_d;
      timeout_q        <= timeout_d;
      edge_count_q     <= edge_count_d;
      reject_count_q   <= reject_count_d;
    end
  end

`ifdef THIELE_LOADER_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  thiele_adjacency_regs #(
    .NODES (NODES),
    .IDX_W (IDX_W)
  ) u_adj (
    .clk       (clk),
    .reset     (reset),
    .clear     (adj_clear),
    .set_en    (adj_set),
    .u         (edge_u),
    .v         (edge_v),
    .adjacency (adjacency)
  );

  assign edge_ready     = (state_q == ST_LOAD);
  assign busy           = (state_q != ST_IDLE);
  assign solver_start   = solver_start_q;
  assign result_valid   = result_valid_q;
  assign result_success = result_success_q;
  assign load_error     = load_error_q;
  assign edge_count     = edge_count_q;
  assign reject_count   = reject_count_q;
  assign timeout        = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_thiele_graph_loader.sv
// ============================================================================
// tb_thiele_graph_loader : scoreboard bench with a behavioural solver model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_thiele_graph_loader;

  localparam int NODES = 9;
  localparam int IDX_W = 8;
  localparam int CNT_W = 16;
  localparam int WD    = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_start = 1'b0;
  logic edge_valid = 1'b0;
  logic edge_last = 1'b0;
  logic [IDX_W-1:0] edge_u = '0;
  logic [IDX_W-1:0] edge_v = '0;
  logic solver_done = 1'b0;
  logic solver_success = 1'b0;
  logic edge_ready, solver_start, busy, result_valid, result_success, load_error, timeout;
  logic [NODES*NODES-1:0] adjacency;
  logic [CNT_W-1:0] edge_count, reject_count;

  thiele_graph_loader #(
    .NODES(NODES), .IDX_W(IDX_W), .CNT_W(CNT_W), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_u(edge_u), .edge_v(edge_v), .edge_last(edge_last),
    .adjacency(adjacency), .solver_start(solver_start),
    .solver_done(solver_done), .solver_success(solver_success),
    .busy(busy), .result_valid(result_valid), .result_success(result_success),
    .load_error(load_error), .edge_count(edge_count),
    .reject_count(reject_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Solver model: raises done sol_delay cycles into start, drops it once start drops.
  int sol_delay = 5;
  bit sol_succ  = 1'b1;
  bit sol_hang  = 1'b0;
  int sol_cnt   = 0;
  int start_cycles = 0;

  always @(posedge clk) begin
    if (solver_start === 1'b1) start_cycles <= start_cycles + 1;
    if (reset || solver_start !== 1'b1) begin
      sol_cnt     <= 0;
      solver_done <= 1'b0;
    end else if (!sol_hang && !solver_done) begin
      if (sol_cnt == sol_delay - 1) begin
        solver_done    <= 1'b1;
        solver_success <= sol_succ;
      end
      sol_cnt <= sol_cnt + 1;
    end
  end

  typedef struct {
    logic [NODES*NODES-1:0] adj;
    int edges;
    int rejects;
    bit err;
    bit success;
    bit to;
  } exp_t;

  exp_t sb[$];
  logic [NODES*NODES-1:0] m_adj;
  int m_edges;
  int m_rejects;
  bit m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_adj = '0; m_edges = 0; m_rejects = 0; m_err = 1'b0;
  endtask

  task automatic send_edge(input int u, input int v, input bit last);
    edge_u = 8'(u); edge_v = 8'(v); edge_last = last; edge_valid = 1'b1;
    checks++;
    if (edge_ready !== 1'b1) begin
      errors++; $display("FAIL edge_ready during load: got %b want 1", edge_ready);
    end
    if (u < NODES && v < NODES && u != v) begin
      m_adj[u*NODES+v] = 1'b1; m_adj[v*NODES+u] = 1'b1; m_edges++;
    end else begin
      m_rejects++; m_err = 1'b1;
    end
    tick();
    edge_valid = 1'b0; edge_last = 1'b0;
  endtask

  task automatic push_expect(input bit success, input bit to);
    exp_t e;
    e.adj = m_adj; e.edges = m_edges; e.rejects = m_rejects;
    e.err = m_err; e.success = success; e.to = to;
    sb.push_back(e);
  endtask

  // Scoreboard drain: waits for the sticky result, then compares against the oldest entry.
  task automatic wait_result(input string name);
    int n = 0;
    exp_t e;
    while (result_valid !== 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++; $display("FAIL %s result_valid timeout: got %b want 1", name, result_valid);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s scoreboard empty: got 0 entries want 1", name);
    end else begin
      e = sb.pop_front();
      checks += 6;
      if (result_success !== e.success) begin
        errors++; $display("FAIL %s result_success: got %b want %b", name, result_success, e.success);
      end
      if (load_error !== e.err) begin
        errors++; $display("FAIL %s load_error: got %b want %b", name, load_error, e.err);
      end
      if (timeout !== e.to) begin
        errors++; $display("FAIL %s timeout: got %b want %b", name, timeout, e.to);
      end
      if (adjacency !== e.adj) begin
        errors++; $display("FAIL %s adjacency: got %h want %h", name, adjacency, e.adj);
      end
      if (edge_count !== CNT_W'(e.edges)) begin
        errors++; $display("FAIL %s edge_count: got %0d want %0d", name, edge_count, e.edges);
      end
      if (reject_count !== CNT_W'(e.rejects)) begin
        errors++; $display("FAIL %s reject_count: got %0d want %0d", name, reject_count, e.rejects);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || solver_start !== 1'b0) begin
      errors++; $display("FAIL %s idle after result: got busy=%b start=%b want 0 0", name, busy, solver_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({edge_ready, solver_start, busy, result_valid, result_success, load_error, timeout} !== 7'b0
        || adjacency !== '0 || edge_count !== '0 || reject_count !== '0) begin
      errors++;
      $display("FAIL reset outputs: got ready=%b start=%b busy=%b rv=%b rs=%b le=%b to=%b adj=%h ec=%0d rc=%0d want all 0",
               edge_ready, solver_start, busy, result_valid, result_success, load_error, timeout,
               adjacency, edge_count, reject_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_triangle_handshake();
    sol_delay = 5; sol_succ = 1'b1; sol_hang = 1'b0;
    pulse_load();
    checks++;
    if (busy !== 1'b1 || adjacency !== '0) begin
      errors++; $display("FAIL triangle load entry: got busy=%b adj=%h want 1 0", busy, adjacency);
    end
    send_edge(0, 1, 1'b0);
    checks++;
    if (adjacency[0*NODES+1] !== 1'b1 || adjacency[1*NODES+0] !== 1'b1) begin
      errors++; $display("FAIL triangle first edge bits: got %b%b want 11",
                         adjacency[0*NODES+1], adjacency[1*NODES+0]);
    end
    send_edge(1, 2, 1'b0);
    checks++;
    if (solver_start !== 1'b0) begin
      errors++; $display("FAIL triangle early start: got %b want 0", solver_start);
    end
    send_edge(2, 0, 1'b1);
    checks += 3;
    if (solver_start !== 1'b1) begin
      errors++; $display("FAIL triangle start after last: got %b want 1", solver_start);
    end
    if (edge_count !== CNT_W'(3)) begin
      errors++; $display("FAIL triangle edge_count: got %0d want 3", edge_count);
    end
    if (adjacency !== m_adj) begin
      errors++; $display("FAIL triangle adjacency: got %h want %h", adjacency, m_adj);
    end
    push_expect(1'b1, 1'b0);
    wait_result("triangle");
  endtask

  task automatic test_self_loop();
    int s0 = start_cycles;
    pulse_load();
    send_edge(1, 1, 1'b0);
    checks++;
    if (load_error !== 1'b1 || reject_count !== CNT_W'(1) || adjacency !== '0) begin
      errors++; $display("FAIL self_loop reject: got le=%b rc=%0d adj=%h want 1 1 0",
                         load_error, reject_count, adjacency);
    end
    send_edge(0, 2, 1'b1);
    push_expect(1'b0, 1'b0);
    wait_result("self_loop");
    checks++;
    if (start_cycles != s0) begin
      errors++; $display("FAIL self_loop solver launched: got %0d start cycles want 0", start_cycles - s0);
    end
  endtask

  task automatic test_out_of_range();
    logic [NODES*NODES-1:0] snap;
    pulse_load();
    send_edge(0, 1, 1'b0);
    snap = adjacency;
    send_edge(9, 3, 1'b0);
    checks++;
    if (adjacency !== snap || load_error !== 1'b1) begin
      errors++; $display("FAIL range u=9: got adj=%h le=%b want adj=%h le=1", adjacency, load_error, snap);
    end
    send_edge(3, 200, 1'b0);
    send_edge(2, 3, 1'b1);
    push_expect(1'b0, 1'b0);
    wait_result("out_of_range");
  endtask

  task automatic test_restart_k4();
    sol_succ = 1'b0; sol_delay = 3; sol_hang = 1'b0;
    pulse_load();
    send_edge(0, 1, 1'b0);
    send_edge(1, 2, 1'b0);
    pulse_load();
    checks++;
    if (adjacency !== '0 || edge_count !== '0 || edge_ready !== 1'b1 || result_valid !== 1'b0) begin
      errors++; $display("FAIL restart clear: got adj=%h ec=%0d ready=%b rv=%b want 0 0 1 0",
                         adjacency, edge_count, edge_ready, result_valid);
    end
    edge_u = 8'd3; edge_v = 8'd4; edge_valid = 1'b1; edge_last = 1'b1;
    pulse_load();
    edge_valid = 1'b0; edge_last = 1'b0;
    checks++;
    if (adjacency !== '0 || edge_count !== '0 || busy !== 1'b1 || solver_start !== 1'b0) begin
      errors++; $display("FAIL restart priority: got adj=%h ec=%0d busy=%b start=%b want 0 0 1 0",
                         adjacency, edge_count, busy, solver_start);
    end
    send_edge(0, 1, 1'b0); send_edge(0, 2, 1'b0); send_edge(0, 3, 1'b0);
    send_edge(1, 0, 1'b0); send_edge(1, 2, 1'b0); send_edge(1, 3, 1'b0);
    send_edge(2, 3, 1'b1);
    push_expect(1'b0, 1'b0);
    wait_result("restart_k4");
    sol_succ = 1'b1;
  endtask

  task automatic test_watchdog();
`ifdef THIELE_LOADER_WATCHDOG_EN
    int s0;
    int n = 0;
    sol_hang = 1'b1;
    pulse_load();
    send_edge(5, 6, 1'b1);
    s0 = start_cycles;
    while (solver_start === 1'b1 && n < 100) begin tick(); n++; end
    checks += 2;
    if (start_cycles - s0 != WD) begin
      errors++; $display("FAIL watchdog start width: got %0d want %0d", start_cycles - s0, WD);
    end
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL watchdog timeout flag: got %b want 1", timeout);
    end
    push_expect(1'b0, 1'b1);
    wait_result("watchdog");
    sol_hang = 1'b0;
`endif
  endtask

  task automatic test_reset_midrun();
    sol_hang = 1'b1;
    pulse_load();
    send_edge(4, 5, 1'b1);
    checks++;
    if (solver_start !== 1'b1) begin
      errors++; $display("FAIL midrun start: got %b want 1", solver_start);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (solver_start !== 1'b0 || busy !== 1'b0 || adjacency !== '0 || edge_count !== '0) begin
      errors++; $display("FAIL midrun reset: got start=%b busy=%b adj=%h ec=%0d want 0 0 0 0",
                         solver_start, busy, adjacency, edge_count);
    end
    reset = 1'b0;
    sol_hang = 1'b0;
    tick();
  endtask

  initial begin
    m_adj = '0; m_edges = 0; m_rejects = 0; m_err = 1'b0;
    test_reset();
    test_triangle_handshake();
    test_self_loop();
    test_out_of_range();
    test_restart_k4();
    test_watchdog();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/thiele_graph_loader.md
Name: thiele_graph_loader

Overview:
Upstream feeder for the autonomous 3-colouring solver. Accepts an undirected edge stream over a valid/ready handshake and builds the symmetric NODES×NODES adjacency matrix. It then runs the solver's start/done handshake: hold start until done, release, and wait for done to drop. Finally it latches success as a sticky result for the host sequencer.

Parameters:
NODES, 9, graph size; must match the solver instance.
IDX_W, 8, width of edge endpoint indices.
CNT_W, 16, width of the edge counters (saturating).
WATCHDOG_CYCLES, 1000000, solver timeout; used only when the optional feature is compiled in.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
load_start  in  1  pulse: clear the matrix and begin a new graph.
edge_valid  in  1  edge beat valid.
edge_ready  out  1  loader accepts a beat (high only in ST_LOAD).
edge_u  in  IDX_W  endpoint u.
edge_v  in  IDX_W  endpoint v.
edge_last  in  1  final beat of the graph.
adjacency  out  NODES*NODES  bit [u*NODES+v]; symmetric.
solver_start  out  1  to the solver's start input.
solver_done  in  1  from the solver's done output.
solver_success  in  1  from the solver's success output.
busy  out  1  high whenever state != ST_IDLE.
result_valid  out  1  sticky; set at end of run, cleared by load_start.
result_success  out  1  latched solver_success, or 0 on load error.
load_error  out  1  sticky; one or more beats rejected.
edge_count  out  CNT_W  accepted edges, saturating.
reject_count  out  CNT_W  rejected edges, saturating.
timeout  out  1  sticky watchdog flag; tied 0 when the feature is absent.

Behaviour:
- Reset (synchronous): state=ST_IDLE; all outputs 0; adjacency all-zero.
- States: ST_IDLE, ST_LOAD, ST_WAIT_DONE, ST_RELEASE.
- ST_IDLE:
  - On load_start: clear adjacency, edge_count, reject_count, result_valid, result_success, load_error, timeout; next state ST_LOAD.
  - Edge beats are ignored (edge_ready=0).
- ST_LOAD, per beat (edge_valid & edge_ready):
  - A beat is rejected if u>=NODES, v>=NODES, or u==v. A rejected beat sets load_error, increments reject_count, and leaves adjacency unchanged.
  - Otherwise, set bits [u*NODES+v] and [v*NODES+u], visible the next cycle. Duplicate edges are idempotent but still counted.
  - If edge_last is on the beat (accepted or rejected):
    - load_error (including this beat) clear → solver_start<=1 and next state ST_WAIT_DONE.
    - load_error set → result_valid<=1, result_success<=0, next state ST_IDLE; the solver is never launched.
  - load_start in ST_LOAD restarts: clears as in ST_IDLE and stays in ST_LOAD. It takes priority over a same-cycle beat.
- ST_WAIT_DONE: solver_start held at 1; adjacency frozen.
  - On solver_done=1: latch solver_success into result_success, solver_start<=0, next state ST_RELEASE.
- ST_RELEASE: solver_start=0.
  - On solver_done=0: result_valid<=1, next state ST_IDLE.
  - This is required because the solver leaves its finished state only after start drops.
- load_start is ignored in ST_WAIT_DONE and ST_RELEASE.
- Counters saturate at 2^CNT_W-1.
- adjacency is stable from ST_WAIT_DONE entry until the next load_start.
- Reset mid-run drops solver_start the following cycle. The solver shares reset, so no handshake recovery is needed.

Optional Feature:
- Macro: THIELE_LOADER_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in ST_WAIT_DONE.
  - When it reaches WATCHDOG_CYCLES: set timeout, set result_success=0, solver_start<=0, next state ST_RELEASE.
  - A late done is ignored for the result.
- Undefined: no counter; timeout tied 0; ST_WAIT_DONE waits indefinitely.

Decomposition:
- Shared package thiele_loader_pkg: state enum (ST_IDLE..ST_RELEASE), default IDX_W/CNT_W, and function edge_ok(u,v,nodes).
- One sub-module, thiele_adjacency_regs: symmetric bit-set and clear register file with set_en/u/v/clear ports. The FSM stays in the top.

Test Plan:
- Triangle, NODES=3: load_start; edges (0,1),(1,2),(2,0 last) → adjacency=9'b011101110; solver_start rises the cycle after the last beat; edge_count=3.
- Self-loop: edges (1,1),(0,2 last) → load_error=1, reject_count=1, result_valid=1, result_success=0; solver_start never asserts.
- Out-of-range index: u=9 with NODES=9 → beat rejected, adjacency unchanged, load_error=1.
- Handshake: model done 5 cycles after start with success=1, then done drops 1 cycle after start drops → result_valid=1, result_success=1; busy low afterwards.
- Restart: load_start mid-load after 2 edges → adjacency=0, edge_count=0, still in ST_LOAD; a subsequent K4 (4 nodes) load completes; solver model returns success=0 → result_success=0.
- With THIELE_LOADER_WATCHDOG_EN and WATCHDOG_CYCLES=20: solver never asserts done → timeout=1 at cycle 20, solver_start low, result_valid=1, result_success=0.
